// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and runs it through EXEC and an optional MEM phase.
// Keeps the cmp flags for later branches and ends a MEM wait on mem_ack or after MEM_TO cycles.
module multicycle_ctrl #(
    parameter int IW     = 9,
    parameter int OPW    = 3,
    parameter int MEM_TO = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           instr_valid,
    input  logic [IW-1:0]  instr,
    output logic           instr_ready,
    input  logic           mem_ack,
    input  logic           alu_lt,
    input  logic           alu_gt,
    input  logic           alu_eq,
    output logic [OPW-1:0] ALUOp,
    output logic           RegWrite,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           ALUSrc,
    output logic           REGSrc,
    output logic           Branch,
    output logic           Jump,
    output logic           retire,
    output logic           illegal,
    output logic           mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM
    } state_t;

    state_t      state, state_nxt;
    logic [IW-1:0] ir;
    logic [2:0]  flags;          // {lt, gt, eq}
    logic [7:0]  cnt;
    logic        ir_load, flags_load, cnt_inc;
    logic        taken;

    logic [1:0]  typ;
    logic [2:0]  op;
    logic        is_ld;

    assign typ   = ir[IW-1:IW-2];
    assign op    = ir[IW-3:IW-5];
    assign is_ld = (op == 3'b010);

    always_comb begin
        case (op[2:1])
            2'b00:   taken = flags[2];
            2'b01:   taken = flags[1];
            2'b10:   taken = ~flags[0];
            default: taken = flags[0];
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            ir    <= '0;
            flags <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load)
                ir <= instr;
            if (flags_load)
                flags <= {alu_lt, alu_gt, alu_eq};
            // Counter is held at zero outside MEM so every MEM entry starts fresh.
            cnt <= cnt_inc ? cnt + 8'd1 : '0;
        end
    end

    always_comb begin
        state_nxt   = state;
        ir_load     = 1'b0;
        flags_load  = 1'b0;
        cnt_inc     = 1'b0;
        instr_ready = 1'b0;
        ALUOp       = '0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrc      = 1'b0;
        REGSrc      = 1'b0;
        Branch      = 1'b0;
        Jump        = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;

        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                state_nxt = S_IDLE;
                retire    = 1'b1;
                case (typ)
                    2'b00: begin
                        ALUOp    = OPW'(op);
                        RegWrite = 1'b1;
                    end
                    2'b01: begin
                        Branch = taken;
                    end
                    2'b10: begin
                        case (op)
                            3'b000: begin
                                ALUSrc   = 1'b1;
                                RegWrite = 1'b1;
                            end
                            3'b010: begin
                                MemtoReg  = 1'b1;
                                retire    = 1'b0;
                                state_nxt = S_MEM;
                            end
                            3'b011: begin
                                MemWrite  = 1'b1;
                                retire    = 1'b0;
                                state_nxt = S_MEM;
                            end
                            3'b100:  flags_load = 1'b1;
                            3'b101:  ;
                            default: illegal = 1'b1;
                        endcase
                    end
                    default: begin
                        if (op[2]) begin
                            Jump = 1'b1;
                        end else begin
                            REGSrc   = 1'b1;
                            RegWrite = 1'b1;
                        end
                    end
                endcase
            end

            S_MEM: begin
                MemtoReg = is_ld;
                MemWrite = ~is_ld;
                if (mem_ack) begin
                    retire    = 1'b1;
                    RegWrite  = is_ld;
                    state_nxt = S_IDLE;
                end else if (cnt == 8'(MEM_TO - 1)) begin
                    retire    = 1'b1;
                    mem_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every EXEC/MEM/IDLE cycle is compared against a hand-built control vector.
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       mem_ack;
    logic       alu_lt, alu_gt, alu_eq;
    logic [2:0] ALUOp;
    logic       RegWrite, MemWrite, MemtoReg, ALUSrc, REGSrc, Branch, Jump;
    logic       retire, illegal, mem_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] RW = 10'b1000000000;
    localparam logic [9:0] MW = 10'b0100000000;
    localparam logic [9:0] MR = 10'b0010000000;
    localparam logic [9:0] AS = 10'b0001000000;
    localparam logic [9:0] RS = 10'b0000100000;
    localparam logic [9:0] BR = 10'b0000010000;
    localparam logic [9:0] JP = 10'b0000001000;
    localparam logic [9:0] RT = 10'b0000000100;
    localparam logic [9:0] IL = 10'b0000000010;
    localparam logic [9:0] ME = 10'b0000000001;
    localparam logic [9:0] NONE = 10'b0000000000;

    logic [13:0] obs;
    assign obs = {instr_ready, ALUOp, RegWrite, MemWrite, MemtoReg, ALUSrc,
                  REGSrc, Branch, Jump, retire, illegal, mem_err};

    multicycle_ctrl #(.IW(9), .OPW(3), .MEM_TO(8)) dut (
        .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_ack(mem_ack),
        .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_eq(alu_eq),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .REGSrc(REGSrc), .Branch(Branch), .Jump(Jump),
        .retire(retire), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [13:0] v(input logic rdy, input logic [2:0] aop, input logic [9:0] c);
        return {rdy, aop, c};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] exp);
        #1;
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, obs, exp);
        end
    endtask

    // Present one instruction in IDLE; returns positioned inside its EXEC cycle.
    task automatic issue(input logic [8:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0;
        alu_lt = 1'b0; alu_gt = 1'b0; alu_eq = 1'b0;
        #12;
        chk("reset_state", v(1, 3'd0, NONE));
        Reset = 1'b1;
        tick();
        chk("idle_after_reset", v(1, 3'd0, NONE));

        // ld aborted by reset during MEM
        issue(9'b10_010_0000);
        chk("ld_exec", v(0, 3'd0, MR));
        tick();
        chk("ld_mem1", v(0, 3'd0, MR));
        Reset = 1'b0;
        chk("abort_reset", v(1, 3'd0, NONE));
        #2;
        Reset = 1'b1;
        tick();
        chk("abort_idle", v(1, 3'd0, NONE));

        issue(9'b00_000_101);
        chk("add_exec", v(0, 3'd0, RW | RT));
        tick();
        chk("add_idle", v(1, 3'd0, NONE));
        issue(9'b00_101_0000);
        chk("math5_exec", v(0, 3'd5, RW | RT));
        tick();

        // flags cleared by reset: bl not taken, bne taken
        issue(9'b01_000_0000);
        chk("bl_reset_flags", v(0, 3'd0, RT));
        tick();
        issue(9'b01_100_0000);
        chk("bne_reset_flags", v(0, 3'd0, BR | RT));
        tick();

        // cmp with lt, then branches
        alu_lt = 1'b1;
        issue(9'b10_100_0000);
        chk("cmp_exec", v(0, 3'd0, RT));
        tick();
        alu_lt = 1'b0;
        issue(9'b01_110_0000);
        chk("beq_lt", v(0, 3'd0, RT));
        tick();
        issue(9'b01_000_0000);
        chk("bl_lt", v(0, 3'd0, BR | RT));
        tick();
        issue(9'b10_101_0000);
        chk("nop_exec", v(0, 3'd0, RT));
        tick();
        issue(9'b01_000_0000);
        chk("bl_persist", v(0, 3'd0, BR | RT));
        tick();
        issue(9'b01_010_0000);
        chk("bg_lt", v(0, 3'd0, RT));
        tick();

        // cmp with eq, then beq/bne
        alu_eq = 1'b1;
        issue(9'b10_100_0000);
        tick();
        alu_eq = 1'b0;
        issue(9'b01_111_0000);
        chk("beq_eq", v(0, 3'd0, BR | RT));
        tick();
        issue(9'b01_101_0000);
        chk("bne_eq", v(0, 3'd0, RT));
        tick();

        // ld with ack after three idle MEM cycles; ack in IDLE is ignored
        mem_ack = 1'b1;
        chk("ack_in_idle", v(1, 3'd0, NONE));
        mem_ack = 1'b0;
        issue(9'b10_010_0000);
        chk("ld2_exec", v(0, 3'd0, MR));
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("ld2_mem%0d", i), v(0, 3'd0, MR));
        end
        tick();
        mem_ack = 1'b1;
        chk("ld2_ack", v(0, 3'd0, MR | RW | RT));
        tick();
        mem_ack = 1'b0;
        chk("ld2_idle", v(1, 3'd0, NONE));

        // st with no ack: timeout on the 8th MEM cycle
        issue(9'b10_011_0000);
        chk("st_exec", v(0, 3'd0, MW));
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("st_mem%0d", i), v(0, 3'd0, MW));
        end
        tick();
        chk("st_timeout", v(0, 3'd0, MW | RT | ME));
        tick();
        chk("st_idle", v(1, 3'd0, NONE));

        // undefined type-10 opcodes
        issue(9'b10_110_0000);
        chk("ill_110", v(0, 3'd0, IL | RT));
        tick();
        issue(9'b10_001_0000);
        chk("ill_001", v(0, 3'd0, IL | RT));
        tick();
        issue(9'b10_111_0000);
        chk("ill_111", v(0, 3'd0, IL | RT));
        tick();

        // back-to-back li, mov, jmp with instr_valid held high
        instr_valid = 1'b1;
        instr = 9'b10_000_0000;
        tick();
        chk("li_exec", v(0, 3'd0, AS | RW | RT));
        instr = 9'b11_000_0000;
        tick();
        chk("b2b_idle1", v(1, 3'd0, NONE));
        tick();
        chk("mov_exec", v(0, 3'd0, RS | RW | RT));
        instr = 9'b11_100_0000;
        tick();
        chk("b2b_idle2", v(1, 3'd0, NONE));
        tick();
        chk("jmp_exec", v(0, 3'd0, JP | RT));
        instr_valid = 1'b0;
        tick();
        chk("b2b_idle3", v(1, 3'd0, NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
